hex_display_scroller: RTL and testbench

- Parametrised, clocked successor to the combinational state-to-text hex display block.
- Drives NUM_DIGITS 7-segment digits from a loaded message of up to MSG_LEN 5-bit character codes.
- Modes: static text, circular scrolling text, or a latched hex value with leading-zero blanking; optional blinking.
- Sits between the memory-controller FSM / status logic and the board HEX outputs, one hexDriver per digit.

---
 rtl/hex_display_scroller.sv | 219 +++++++++++++++++++++
 tb/tb_hex_display_scroller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scroller.sv
// hex_display_scroller: clocked driver for NUM_DIGITS 7-segment digits.
// Shows a loaded message statically or as a circular scroll, or a latched
// hex value with leading-zero blanking, with optional blinking.
module hex_display_scroller #(
  parameter int NUM_DIGITS  = 6,
  parameter int MSG_LEN     = 16,
  parameter int VALUE_WIDTH = 16,
  parameter int SCROLL_DIV  = 12_500_000,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [1:0]                     load_mode,
  input  logic                           load_blink,
  input  logic [$clog2(MSG_LEN+1)-1:0]   load_len,
  input  logic [5*MSG_LEN-1:0]           load_msg,
  input  logic [VALUE_WIDTH-1:0]         load_value,
  input  logic                           hold,
  output logic [5*NUM_DIGITS-1:0]        char_out,
  output logic [8*NUM_DIGITS-1:0]        seg_out,
  output logic                           wrap_pulse
);

  localparam int LEN_W    = $clog2(MSG_LEN + 1);
  localparam int RING_MAX = MSG_LEN + NUM_DIGITS;
  // Offset plus digit position can reach almost twice the ring length.
  localparam int IDX_W    = $clog2(2 * RING_MAX);
  localparam int SDIV_W   = $clog2(SCROLL_DIV + 1);
  localparam int BDIV_W   = $clog2(BLINK_DIV + 1);
  localparam int NIB      = (VALUE_WIDTH + 3) / 4;
  localparam int EXT_W    = 4 * NUM_DIGITS;
  localparam logic [4:0] BLANK = 5'd23;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_SCROLL = 2'd1,
    MODE_VALUE  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  mode_e                    mode_q, mode_d;
  logic                     blink_q, blink_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [5*MSG_LEN-1:0]     msg_q, msg_d;
  logic [VALUE_WIDTH-1:0]   value_q, value_d;
  logic [IDX_W-1:0]         offset_q, offset_d;
  logic [SDIV_W-1:0]        sdiv_q, sdiv_d;
  logic [BDIV_W-1:0]        bdiv_q, bdiv_d;
  logic                     hidden_q, hidden_d;
  logic                     wrap_q, wrap_d;
  logic                     ready_q;
  logic [5*NUM_DIGITS-1:0]  char_q, char_d;

  logic                     accept;
  logic                     scroll_active;
  logic [IDX_W-1:0]         ring_last;
  logic [LEN_W-1:0]         len_clamped;
  logic [EXT_W-1:0]         value_ext;

  // Character k of the message, BLANK when k lies outside the buffer.
  function automatic logic [4:0] msg_char(input logic [5*MSG_LEN-1:0] m, input int idx);
    msg_char = BLANK;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (idx == i) msg_char = m[5*i +: 5];
    end
  endfunction

  // Active-low segment pattern {dp,g,f,e,d,c,b,a} for one character code.
  function automatic logic [7:0] hex_seg(input logic [4:0] c);
    case (c)
      5'd0:  hex_seg = 8'hC0;
      5'd1:  hex_seg = 8'hF9;
      5'd2:  hex_seg = 8'hA4;
      5'd3:  hex_seg = 8'hB0;
      5'd4:  hex_seg = 8'h99;
      5'd5:  hex_seg = 8'h92;
      5'd6:  hex_seg = 8'h82;
      5'd7:  hex_seg = 8'hF8;
      5'd8:  hex_seg = 8'h80;
      5'd9:  hex_seg = 8'h90;
      5'd10: hex_seg = 8'h88;
      5'd11: hex_seg = 8'h83;
      5'd12: hex_seg = 8'hC6;
      5'd13: hex_seg = 8'hA1;
      5'd14: hex_seg = 8'h86;
      5'd15: hex_seg = 8'h8E;
      5'd16: hex_seg = 8'hAF;  // r
      5'd17: hex_seg = 8'hA1;  // d
      5'd18: hex_seg = 8'h87;  // t
      5'd19: hex_seg = 8'hF7;  // _
      5'd20: hex_seg = 8'hBF;  // -
      5'd21: hex_seg = 8'hAB;  // n
      5'd22: hex_seg = 8'h7F;  // .
      default: hex_seg = 8'hFF;
    endcase
  endfunction

  assign accept        = load_valid && ready_q;
  assign scroll_active = (mode_q == MODE_SCROLL) && (len_q != '0);
  assign ring_last     = IDX_W'(len_q) + IDX_W'(NUM_DIGITS - 1);
  assign len_clamped   = (load_len > LEN_W'(MSG_LEN)) ? LEN_W'(MSG_LEN) : load_len;
  assign value_ext     = EXT_W'(value_q);

  // Next state: a load overrides any scroll or blink terminal count in the same cycle.
  always_comb begin
    mode_d   = mode_q;
    blink_d  = blink_q;
    len_d    = len_q;
    msg_d    = msg_q;
    value_d  = value_q;
    offset_d = offset_q;
    sdiv_d   = sdiv_q;
    bdiv_d   = bdiv_q;
    hidden_d = hidden_q;
    wrap_d   = 1'b0;
    if (accept) begin
      mode_d   = mode_e'(load_mode);
      blink_d  = load_blink;
      len_d    = len_clamped;
      msg_d    = load_msg;
      value_d  = load_value;
      offset_d = '0;
      sdiv_d   = '0;
      bdiv_d   = '0;
      hidden_d = 1'b0;
    end else if (!hold) begin
      if (scroll_active) begin
        if (sdiv_q == SDIV_W'(SCROLL_DIV - 1)) begin
          sdiv_d = '0;
          if (offset_q >= ring_last) begin
            offset_d = '0;
            wrap_d   = 1'b1;
          end else begin
            offset_d = offset_q + 1'b1;
          end
        end else begin
          sdiv_d = sdiv_q + 1'b1;
        end
      end
      if (blink_q) begin
        if (bdiv_q == BDIV_W'(BLINK_DIV - 1)) begin
          bdiv_d   = '0;
          hidden_d = ~hidden_q;
        end else begin
          bdiv_d = bdiv_q + 1'b1;
        end
      end else begin
        bdiv_d   = '0;
        hidden_d = 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    // Message position shown on this digit; the leftmost digit shows position 0.
    localparam int K = NUM_DIGITS - 1 - gi;
    logic [4:0] chr;
    logic       nz;

    assign nz = |value_ext[EXT_W-1:4*gi];

    // Character this digit should show given the current mode and state.
    always_comb begin
      int li;
      int idx;
      chr = BLANK;
      li  = int'(len_q);
      idx = int'(offset_q) + K;
      if (idx >= li + NUM_DIGITS) idx = idx - (li + NUM_DIGITS);
      case (mode_q)
        MODE_STATIC: if (K < li) chr = msg_char(msg_q, K);
        MODE_SCROLL: if (li != 0 && idx < li) chr = msg_char(msg_q, idx);
        MODE_VALUE:  if (gi < NIB && (gi == 0 || nz)) chr = {1'b0, value_ext[4*gi +: 4]};
        default:     chr = BLANK;
      endcase
    end

    assign char_d[5*gi +: 5]  = hidden_q ? BLANK : chr;
    assign seg_out[8*gi +: 8] = hex_seg(char_q[5*gi +: 5]);
  end

  // State and registered display, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_STATIC;
      blink_q  <= 1'b0;
      len_q    <= '0;
      msg_q    <= {MSG_LEN{BLANK}};
      value_q  <= '0;
      offset_q <= '0;
      sdiv_q   <= '0;
      bdiv_q   <= '0;
      hidden_q <= 1'b0;
      wrap_q   <= 1'b0;
      ready_q  <= 1'b0;
      char_q   <= {NUM_DIGITS{BLANK}};
    end else begin
      mode_q   <= mode_d;
      blink_q  <= blink_d;
      len_q    <= len_d;
      msg_q    <= msg_d;
      value_q  <= value_d;
      offset_q <= offset_d;
      sdiv_q   <= sdiv_d;
      bdiv_q   <= bdiv_d;
      hidden_q <= hidden_d;
      wrap_q   <= wrap_d;
      ready_q  <= 1'b1;
      char_q   <= char_d;
    end
  end

  assign load_ready = ready_q;
  assign char_out   = char_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_hex_display_scroller.sv
// Directed bench for hex_display_scroller (6 digits, 8-char message,
// scroll every 4 cycles, blink half-period 3 cycles).
module tb_hex_display_scroller;

  localparam int ND = 6;
  localparam int ML = 8;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [1:0]  load_mode;
  logic        load_blink;
  logic [3:0]  load_len;
  logic [39:0] load_msg;
  logic [15:0] load_value;
  logic        hold;
  logic [29:0] char_out;
  logic [47:0] seg_out;
  logic        wrap_pulse;

  int tests = 0;
  int fails = 0;
  logic [4:0] ex_msg [8];

  localparam logic [29:0] ALL_BLANK = {6{5'd23}};

  hex_display_scroller #(
    .NUM_DIGITS(ND), .MSG_LEN(ML), .VALUE_WIDTH(16), .SCROLL_DIV(4), .BLINK_DIV(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_mode(load_mode), .load_blink(load_blink), .load_len(load_len),
    .load_msg(load_msg), .load_value(load_value), .hold(hold),
    .char_out(char_out), .seg_out(seg_out), .wrap_pulse(wrap_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [29:0] p6(input logic [4:0] a5, a4, a3, a2, a1, a0);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [39:0] m8(input logic [4:0] c0, c1, c2, c3, c4, c5, c6, c7);
    return {c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  // Expected scroll frame: ring = message then 6 blanks, leftmost digit first.
  function automatic logic [29:0] ring_exp(input int off, input int len);
    logic [29:0] r;
    logic [2:0]  i3;
    int          idx;
    r = '0;
    for (int k = 0; k < ND; k++) begin
      idx = (off + k) % (len + ND);
      i3  = 3'(idx);
      r   = {r[24:0], (idx < len) ? ex_msg[i3] : 5'd23};
    end
    return r;
  endfunction

  // Presents one load for a single accept edge.
  task automatic do_load(input logic [1:0] mode, input logic bl, input logic [3:0] len,
                         input logic [39:0] msg, input logic [15:0] val);
    load_valid = 1'b1;
    load_mode  = mode;
    load_blink = bl;
    load_len   = len;
    load_msg   = msg;
    load_value = val;
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    logic [29:0] read_exp;
    int          wraps;
    int          first_wrap;

    rst_n = 1'b0; load_valid = 1'b0; load_mode = 2'd0; load_blink = 1'b0;
    load_len = 4'd0; load_msg = '0; load_value = 16'h0; hold = 1'b0;
    for (int i = 0; i < 8; i++) ex_msg[i] = 5'd23;

    // 1. Reset release
    repeat (3) @(posedge clk);
    #1;
    chk("ready_in_reset", 64'(load_ready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 64'(load_ready), 64'd0);
    step();
    chk("ready_after_edge", 64'(load_ready), 64'd1);
    chk("reset_chars", 64'(char_out), 64'(ALL_BLANK));
    chk("reset_segs", 64'(seg_out), 64'hFFFF_FFFF_FFFF);
    chk("reset_wrap", 64'(wrap_pulse), 64'd0);

    // 2. STATIC "rEAd"
    read_exp = p6(5'd16, 5'd14, 5'd10, 5'd17, 5'd23, 5'd23);
    do_load(2'd0, 1'b0, 4'd4, m8(16, 14, 10, 17, 23, 23, 23, 23), 16'h0);
    chk("static_latency", 64'(char_out), 64'(ALL_BLANK));
    step();
    chk("static_chars", 64'(char_out), 64'(read_exp));
    chk("static_segs", 64'(seg_out), 64'hAF86_88A1_FFFF);
    for (int c = 0; c < 100; c++) begin
      step();
      chk("static_stable", 64'(char_out), 64'(read_exp));
    end

    // 3. SCROLL {1,2}: ring length 8, step every 4 cycles
    ex_msg[0] = 5'd1; ex_msg[1] = 5'd2;
    do_load(2'd1, 1'b0, 4'd2, m8(1, 2, 23, 23, 23, 23, 23, 23), 16'h0);
    wraps = 0;
    for (int c = 1; c <= 64; c++) begin
      step();
      chk("scroll_frame", 64'(char_out), 64'(ring_exp(((c - 1) / 4) % 8, 2)));
      chk("scroll_wrap", 64'(wrap_pulse), 64'((c % 32) == 0));
      if (wrap_pulse) wraps++;
    end
    chk("scroll_wrap_count", 64'(wraps), 64'd2);

    // 6a. Load on the scroll terminal edge restarts at offset 0
    repeat (3) step();
    ex_msg[0] = 5'd3; ex_msg[1] = 5'd4;
    do_load(2'd1, 1'b0, 4'd2, m8(3, 4, 23, 23, 23, 23, 23, 23), 16'h0);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("load_wins_off0", 64'(char_out), 64'(ring_exp(0, 2)));
    end
    step();
    chk("load_wins_off1", 64'(char_out), 64'(ring_exp(1, 2)));

    // Length 15 clamps to 8: ring 14, first wrap after 56 cycles
    do_load(2'd1, 1'b0, 4'd15, m8(0, 1, 2, 3, 4, 5, 6, 7), 16'h0);
    first_wrap = 0;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (wrap_pulse && first_wrap == 0) first_wrap = c;
    end
    chk("clamp_wrap_cycle", 64'(first_wrap), 64'd56);

    // SCROLL with len 0: blank, never wraps
    do_load(2'd1, 1'b0, 4'd0, m8(1, 2, 3, 4, 5, 6, 7, 8), 16'h0);
    wraps = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (wrap_pulse) wraps++;
    end
    chk("len0_blank", 64'(char_out), 64'(ALL_BLANK));
    chk("len0_no_wrap", 64'(wraps), 64'd0);

    // 4. VALUE mode (first load made while hold is high)
    hold = 1'b1;
    do_load(2'd2, 1'b0, 4'd0, '0, 16'h00A5);
    step();
    chk("value_00A5", 64'(char_out), 64'(p6(23, 23, 23, 23, 10, 5)));
    hold = 1'b0;
    do_load(2'd2, 1'b0, 4'd0, '0, 16'h0000);
    step();
    chk("value_0000", 64'(char_out), 64'(p6(23, 23, 23, 23, 23, 0)));
    chk("value_0000_seg0", 64'(seg_out[7:0]), 64'hC0);
    do_load(2'd2, 1'b0, 4'd0, '0, 16'h1000);
    step();
    chk("value_1000", 64'(char_out), 64'(p6(23, 23, 1, 0, 0, 0)));

    // Reserved mode shows nothing
    do_load(2'd3, 1'b0, 4'd4, m8(16, 14, 10, 17, 23, 23, 23, 23), 16'h1234);
    step();
    chk("mode3_blank", 64'(char_out), 64'(ALL_BLANK));

    // 5. Blink: 3 visible, 3 hidden; hold freezes the hidden phase
    do_load(2'd0, 1'b1, 4'd4, m8(16, 14, 10, 17, 23, 23, 23, 23), 16'h0);
    for (int c = 1; c <= 10; c++) begin
      step();
      chk("blink_phase", 64'(char_out),
          64'(((((c - 1) / 3) % 2) == 0) ? read_exp : ALL_BLANK));
    end
    hold = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("blink_hold", 64'(char_out), 64'(ALL_BLANK));
    end
    hold = 1'b0;
    step();
    chk("blink_resume1", 64'(char_out), 64'(ALL_BLANK));
    step();
    chk("blink_resume2", 64'(char_out), 64'(ALL_BLANK));
    step();
    chk("blink_resume3", 64'(char_out), 64'(read_exp));

    // 6b. Asynchronous reset mid-scroll
    ex_msg[0] = 5'd1; ex_msg[1] = 5'd2;
    do_load(2'd1, 1'b0, 4'd2, m8(1, 2, 23, 23, 23, 23, 23, 23), 16'h0);
    repeat (10) step();
    chk("pre_reset_frame", 64'(char_out), 64'(ring_exp(2, 2)));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_chars", 64'(char_out), 64'(ALL_BLANK));
    chk("async_segs", 64'(seg_out), 64'hFFFF_FFFF_FFFF);
    chk("async_ready", 64'(load_ready), 64'd0);
    chk("async_wrap", 64'(wrap_pulse), 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rerelease_ready0", 64'(load_ready), 64'd0);
    step();
    chk("rerelease_ready1", 64'(load_ready), 64'd1);
    repeat (20) step();
    chk("rerelease_blank", 64'(char_out), 64'(ALL_BLANK));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
